// File: rtl/stream_demux_n_if.sv
// rtl/stream_demux_n_if.sv - producer and per-channel consumer signals of the 1-to-N stream demux
// master: producer/consumer side; slave: the demux itself.
interface stream_demux_n_if #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4
);
  localparam int SEL_W = $clog2(N_OUT);

  logic [DATA_W-1:0]       in_data;
  logic [SEL_W-1:0]        in_sel;
  logic                    in_last;
  logic                    in_valid;
  logic                    in_ready;
  logic [N_OUT*DATA_W-1:0] out_data;
  logic [N_OUT-1:0]        out_last;
  logic [N_OUT-1:0]        out_valid;
  logic [N_OUT-1:0]        out_ready;
  logic                    sel_err;

  modport master (
    output in_data, in_sel, in_last, in_valid, out_ready,
    input  in_ready, out_data, out_last, out_valid, sel_err
  );

  modport slave (
    input  in_data, in_sel, in_last, in_valid, out_ready,
    output in_ready, out_data, out_last, out_valid, sel_err
  );
endinterface

// File: rtl/stream_demux_n.sv
// rtl/stream_demux_n.sv - 1-to-N valid/ready stream demux with one holding register per channel
// Optional packet-lock routing (IDLE/LOCK/DROP) is enabled by defining STREAM_DEMUX_PKT_LOCK_EN.
module stream_demux_n #(
  parameter int DATA_W = 8,
  parameter int N_OUT  = 4
) (
  input  logic           clk,
  input  logic           rst,
  stream_demux_n_if.slave bus
);
  localparam int SEL_W = $clog2(N_OUT);

  logic [N_OUT-1:0]  valid_q;
  logic [N_OUT-1:0]  last_q;
  logic [DATA_W-1:0] data_q [N_OUT];
  logic [N_OUT-1:0]  hit;
  logic [N_OUT-1:0]  load;
  logic [SEL_W-1:0]  esel;
  logic              sel_ok;
  logic              drop_mode;
  logic              accept;
  logic              sel_err_q;

  // Out-of-range selects only exist when N_OUT is not a power of two.
  generate
    if ((1 << SEL_W) == N_OUT) begin : g_pow2
      assign sel_ok = 1'b1;
    end else begin : g_npow2
      assign sel_ok = (esel < SEL_W'(N_OUT));
    end
  endgenerate

`ifdef STREAM_DEMUX_PKT_LOCK_EN
  typedef enum logic [1:0] {IDLE, LOCK, DROP} state_t;

  state_t           state_q, state_d;
  logic [SEL_W-1:0] lock_sel_q, lock_sel_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      lock_sel_q <= '0;
    end else begin
      state_q    <= state_d;
      lock_sel_q <= lock_sel_d;
    end
  end

  // Routing depends only on registered state so in_ready never loops back into esel.
  always_comb begin
    esel      = (state_q == LOCK) ? lock_sel_q : bus.in_sel;
    drop_mode = (state_q == DROP);
  end

  always_comb begin
    state_d    = state_q;
    lock_sel_d = lock_sel_q;
    case (state_q)
      IDLE: begin
        if (accept && !bus.in_last) begin
          state_d    = sel_ok ? LOCK : DROP;
          lock_sel_d = bus.in_sel;
        end
      end
      LOCK, DROP: begin
        if (accept && bus.in_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end
`else
  assign esel      = bus.in_sel;
  assign drop_mode = 1'b0;
`endif

  always_comb begin
    hit = '0;
    for (int k = 0; k < N_OUT; k++) hit[k] = (esel == SEL_W'(k));
  end

  // A selected channel can take a beat when empty or draining this same cycle.
  assign bus.in_ready = drop_mode || !sel_ok || |(hit & (~valid_q | bus.out_ready));
  assign accept       = bus.in_valid && bus.in_ready;
  assign load         = (accept && sel_ok && !drop_mode) ? hit : '0;

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q   <= '0;
      last_q    <= '0;
      sel_err_q <= 1'b0;
      for (int k = 0; k < N_OUT; k++) data_q[k] <= '0;
    end else begin
      sel_err_q <= accept && !sel_ok && !drop_mode;
      for (int k = 0; k < N_OUT; k++) begin
        if (load[k]) begin
          valid_q[k] <= 1'b1;
          data_q[k]  <= bus.in_data;
          last_q[k]  <= bus.in_last;
        end else if (bus.out_ready[k]) begin
          valid_q[k] <= 1'b0;
        end
      end
    end
  end

  generate
    for (genvar g = 0; g < N_OUT; g++) begin : g_pack
      assign bus.out_data[g*DATA_W +: DATA_W] = data_q[g];
    end
  endgenerate

  assign bus.out_valid = valid_q;
  assign bus.out_last  = last_q;
  assign bus.sel_err   = sel_err_q;
endmodule

// File: tb/tb_stream_demux_n.sv
// tb/tb_stream_demux_n.sv - directed vector bench for stream_demux_n (N_OUT=4 and N_OUT=3 instances)
// Routing expectations for the packet-lock build are selected with STREAM_DEMUX_PKT_LOCK_EN.
module tb_stream_demux_n;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  stream_demux_n_if #(.DATA_W(8), .N_OUT(4)) b4 ();
  stream_demux_n_if #(.DATA_W(8), .N_OUT(3)) b3 ();

  stream_demux_n #(.DATA_W(8), .N_OUT(4)) dut4 (.clk(clk), .rst(rst), .bus(b4.slave));
  stream_demux_n #(.DATA_W(8), .N_OUT(3)) dut3 (.clk(clk), .rst(rst), .bus(b3.slave));

  typedef struct {
    logic [7:0] data;
    logic [1:0] sel;
    logic       last;
    logic       valid;
    logic [3:0] ordy;
    logic       exp_rdy;
    logic [3:0] exp_vld;
    int         ch;
    logic [7:0] exp_data;
    logic       exp_last;
  } vec_t;

  vec_t tbl [13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive4(input logic [7:0] d, input logic [1:0] s, input logic l,
                        input logic v, input logic [3:0] r);
    b4.in_data   = d;
    b4.in_sel    = s;
    b4.in_last   = l;
    b4.in_valid  = v;
    b4.out_ready = r;
  endtask

  task automatic drive3(input logic [7:0] d, input logic [1:0] s, input logic l,
                        input logic v, input logic [2:0] r);
    b3.in_data   = d;
    b3.in_sel    = s;
    b3.in_last   = l;
    b3.in_valid  = v;
    b3.out_ready = r;
  endtask

  initial begin
    int lk_ch [3];
    logic [7:0] lk_d [3];
    logic [1:0] lk_s [3];
    logic       lk_l [3];

    tbl[0]  = '{8'h11, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 8'h11, 1'b1};
    tbl[1]  = '{8'h22, 2'd1, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0010, 1, 8'h22, 1'b1};
    tbl[2]  = '{8'h33, 2'd2, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 8'h33, 1'b1};
    tbl[3]  = '{8'h44, 2'd3, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b1000, 3, 8'h44, 1'b1};
    tbl[4]  = '{8'h00, 2'd0, 1'b1, 1'b0, 4'b1111, 1'b1, 4'b0000, 3, 8'h44, 1'b1};
    tbl[5]  = '{8'hA5, 2'd2, 1'b1, 1'b1, 4'b1011, 1'b1, 4'b0100, 2, 8'hA5, 1'b1};
    tbl[6]  = '{8'h5A, 2'd2, 1'b1, 1'b1, 4'b1011, 1'b0, 4'b0100, 2, 8'hA5, 1'b1};
    tbl[7]  = '{8'h5A, 2'd2, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0100, 2, 8'h5A, 1'b1};
    tbl[8]  = '{8'h77, 2'd1, 1'b1, 1'b1, 4'b1011, 1'b1, 4'b0110, 1, 8'h77, 1'b1};
    tbl[9]  = '{8'h66, 2'd1, 1'b1, 1'b1, 4'b1001, 1'b0, 4'b0110, 1, 8'h77, 1'b1};
    tbl[10] = '{8'h12, 2'd0, 1'b0, 1'b1, 4'b1001, 1'b1, 4'b0111, 0, 8'h12, 1'b0};
    tbl[11] = '{8'h34, 2'd0, 1'b1, 1'b1, 4'b1111, 1'b1, 4'b0001, 0, 8'h34, 1'b1};
    tbl[12] = '{8'h00, 2'd0, 1'b0, 1'b0, 4'b1111, 1'b1, 4'b0000, 0, 8'h34, 1'b1};

    drive4(8'h00, 2'd0, 1'b0, 1'b0, 4'b0000);
    drive3(8'h00, 2'd0, 1'b0, 1'b0, 3'b000);
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;

    chk("rst_vld4",  b4.out_valid, 4'b0000);
    chk("rst_vld3",  b3.out_valid, 3'b000);
    chk("rst_data4", b4.out_data, 32'h0);
    chk("rst_last4", b4.out_last, 4'b0000);
    chk("rst_err4",  b4.sel_err, 1'b0);
    chk("rst_err3",  b3.sel_err, 1'b0);
    for (int s = 0; s < 4; s++) begin
      b4.in_sel = 2'(s);
      #1;
      chk($sformatf("rst_rdy4_sel%0d", s), b4.in_ready, 1'b1);
    end
    for (int s = 0; s < 3; s++) begin
      b3.in_sel = 2'(s);
      #1;
      chk($sformatf("rst_rdy3_sel%0d", s), b3.in_ready, 1'b1);
    end

    for (int i = 0; i < 13; i++) begin
      drive4(tbl[i].data, tbl[i].sel, tbl[i].last, tbl[i].valid, tbl[i].ordy);
      #1;
      chk($sformatf("v%0d_rdy", i), b4.in_ready, tbl[i].exp_rdy);
      tick();
      chk($sformatf("v%0d_vld", i), b4.out_valid, tbl[i].exp_vld);
      chk($sformatf("v%0d_data", i), b4.out_data[tbl[i].ch*8 +: 8], tbl[i].exp_data);
      chk($sformatf("v%0d_last", i), b4.out_last[tbl[i].ch], tbl[i].exp_last);
      chk($sformatf("v%0d_err", i), b4.sel_err, 1'b0);
    end

    // Out-of-range select on the 3-channel instance: dropped, one-cycle error pulse.
    drive3(8'hFF, 2'd3, 1'b1, 1'b1, 3'b111);
    #1;
    chk("oor_rdy", b3.in_ready, 1'b1);
    tick();
    chk("oor_vld", b3.out_valid, 3'b000);
    chk("oor_err_hi", b3.sel_err, 1'b1);
    drive3(8'h00, 2'd0, 1'b0, 1'b0, 3'b111);
    tick();
    chk("oor_err_lo", b3.sel_err, 1'b0);
    drive3(8'h02, 2'd2, 1'b1, 1'b1, 3'b111);
    tick();
    chk("oor_next_vld", b3.out_valid, 3'b100);
    chk("oor_next_data", b3.out_data[23:16], 8'h02);
    chk("oor_next_err", b3.sel_err, 1'b0);
    drive3(8'h00, 2'd0, 1'b0, 1'b0, 3'b111);
    tick();

    // Three-beat packet whose later beats carry different selects.
    lk_d = '{8'hA1, 8'hA2, 8'hA3};
    lk_s = '{2'd1, 2'd0, 2'd2};
    lk_l = '{1'b0, 1'b0, 1'b1};
`ifdef STREAM_DEMUX_PKT_LOCK_EN
    lk_ch = '{1, 1, 1};
`else
    lk_ch = '{1, 0, 2};
`endif
    for (int i = 0; i < 3; i++) begin
      drive4(lk_d[i], lk_s[i], lk_l[i], 1'b1, 4'b1111);
      tick();
      chk($sformatf("pkt%0d_vld", i), b4.out_valid, 4'(1 << lk_ch[i]));
      chk($sformatf("pkt%0d_data", i), b4.out_data[lk_ch[i]*8 +: 8], lk_d[i]);
      chk($sformatf("pkt%0d_last", i), b4.out_last[lk_ch[i]], lk_l[i]);
    end
    drive4(8'hC1, 2'd0, 1'b1, 1'b1, 4'b1111);
    tick();
    chk("pkt_next_vld", b4.out_valid, 4'b0001);
    chk("pkt_next_data", b4.out_data[7:0], 8'hC1);

`ifdef STREAM_DEMUX_PKT_LOCK_EN
    // Invalid select on a first beat drops the whole packet with a single error pulse.
    drive3(8'hF0, 2'd3, 1'b0, 1'b1, 3'b111);
    tick();
    chk("drop_err0", b3.sel_err, 1'b1);
    chk("drop_vld0", b3.out_valid, 3'b000);
    drive3(8'hF1, 2'd0, 1'b0, 1'b1, 3'b111);
    #1;
    chk("drop_rdy1", b3.in_ready, 1'b1);
    tick();
    chk("drop_err1", b3.sel_err, 1'b0);
    chk("drop_vld1", b3.out_valid, 3'b000);
    drive3(8'hF2, 2'd1, 1'b1, 1'b1, 3'b111);
    tick();
    chk("drop_vld2", b3.out_valid, 3'b000);
    drive3(8'h03, 2'd0, 1'b1, 1'b1, 3'b111);
    tick();
    chk("drop_after_vld", b3.out_valid, 3'b001);
    chk("drop_after_data", b3.out_data[7:0], 8'h03);
`endif

    // Reset while beats are held on channels 0 and 1 and a packet is open on channel 1.
    drive4(8'h50, 2'd0, 1'b1, 1'b1, 4'b0000);
    tick();
    drive4(8'h51, 2'd1, 1'b0, 1'b1, 4'b0000);
    tick();
    chk("pre_rst_vld", b4.out_valid, 4'b0011);
    drive4(8'h00, 2'd0, 1'b0, 1'b0, 4'b0000);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("mid_rst_vld", b4.out_valid, 4'b0000);
    chk("mid_rst_data", b4.out_data, 32'h0);
    drive4(8'h52, 2'd3, 1'b1, 1'b1, 4'b1111);
    tick();
    chk("post_rst_vld", b4.out_valid, 4'b1000);
    chk("post_rst_data", b4.out_data[31:24], 8'h52);
    drive4(8'h00, 2'd0, 1'b0, 1'b0, 4'b1111);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
